// File: rtl/rca_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one shared 4-bit ripple-carry slice.
// Operands are taken over a valid/ready handshake; the result is offered until the consumer takes it.

module RCA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = c[4];
endmodule

module rca_seq_ctrl #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       nib_s;
  logic             nib_c;
  logic [WIDTH-1:0] sum_shift;
  logic             last_nib;

  RCA u_rca (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .c_in  (carry_q),
    .s     (nib_s),
    .c_out (nib_c)
  );

  // Each slice result enters the sum register from the top, so after NIB steps it is aligned.
  if (NIB == 1) begin : g_sum_one
    assign sum_shift = nib_s;
  end else begin : g_sum_many
    assign sum_shift = {nib_s, sum_q[WIDTH-1:4]};
  end

  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = sum_shift;
        carry_d = nib_c;
        cnt_d   = cnt_q + CW'(1);
        // On the last step the slice sees the operand MSBs at bit 3.
        if (last_nib) begin
          cout_d = nib_c;
          ovf_d  = (a_q[3] ~^ b_q[3]) & (a_q[3] ^ nib_s[3]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: a WIDTH=16 instance driven from a vector table plus random operations,
// and a WIDTH=4 instance for the single-nibble case.

module tb_rca_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid16 = 1'b0, in_ready16, sub16 = 1'b0, cin16 = 1'b0;
  logic        out_valid16, out_ready16 = 1'b0, cout16, ovf16, busy16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  logic        in_valid4 = 1'b0, in_ready4, sub4 = 1'b0, cin4 = 1'b0;
  logic        out_valid4, out_ready4 = 1'b0, cout4, ovf4, busy4;
  logic [3:0]  a4 = '0, b4 = '0, sum4;

  rca_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  rca_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sub(sub4), .cin(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          hold;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on the whole operands, signed overflow from the true signed sum.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic s, input logic c, output logic [15:0] r,
                                output logic co, output logic ov);
    int mask, half, ua, ube, c0, tot, sa, sbe, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(a) & mask;
    ube  = s ? (~int'(b) & mask) : (int'(b) & mask);
    c0   = s ? 1 : int'(c);
    tot  = ua + ube + c0;
    r    = 16'(tot & mask);
    co   = ((tot >> w) & 1) != 0;
    sa   = (ua  >= half) ? ua  - (1 << w) : ua;
    sbe  = (ube >= half) ? ube - (1 << w) : ube;
    sr   = sa + sbe + c0;
    ov   = (sr > half - 1) || (sr < -half);
  endfunction

  task automatic run_op16(input vec_t v);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready16, 1);
    a16 = v.a; b16 = v.b; sub16 = v.sub; cin16 = v.cin; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
    chk("busy_run", busy16, 1);
    chk("in_ready_run", in_ready16, 0);
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("busy_done", busy16, 1);
    chk("sum", sum16, v.s);
    chk("cout", cout16, v.co);
    chk("ovf", ovf16, v.ov);
    $display("op16 a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d hold=%0d",
             v.a, v.b, v.sub, v.cin, sum16, cout16, ovf16, lat, v.hold);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      in_valid16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid16, 1);
      chk("bp_in_ready", in_ready16, 0);
      chk("bp_sum", sum16, v.s);
      chk("bp_cout", cout16, v.co);
      chk("bp_ovf", ovf16, v.ov);
    end
    @(negedge clk);
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    chk("post_out_valid", out_valid16, 0);
    chk("post_in_ready", in_ready16, 1);
    chk("post_busy", busy16, 0);
    chk("post_sum_held", sum16, v.s);
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic c,
                         input logic [3:0] er, input logic eco, input logic eov);
    int lat;
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; cin4 = c; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency4", lat, 1);
    chk("sum4", sum4, er);
    chk("cout4", cout4, eco);
    chk("ovf4", ovf4, eov);
    $display("op4  a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             a, b, s, c, sum4, cout4, ovf4, lat);
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("post_out_valid4", out_valid4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    vec_t        v;
    logic [15:0] r;
    logic        co, ov;
    logic [3:0]  ra, rb;
    logic        rs, rc;

    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 0};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 5};
    tbl[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2};

    #12;
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_sum", sum16, 0);
    chk("rst_cout", cout16, 0);
    chk("rst_ovf", ovf16, 0);
    chk("rst_busy", busy16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready16, 1);

    for (int i = 0; i < 8; i++) run_op16(tbl[i]);

    // Reset two edges into RUN must clear everything without waiting for a clock.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid16, 0);
    chk("midrst_busy", busy16, 0);
    chk("midrst_sum", sum16, 0);
    chk("midrst_cout", cout16, 0);
    chk("midrst_ovf", ovf16, 0);
    $display("mid-run reset applied: busy=%0d sum=%h", busy16, sum16);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0};
    run_op16(v);

    for (int i = 0; i < 30; i++) begin
      v.a = 16'($urandom); v.b = 16'($urandom);
      v.sub = 1'($urandom); v.cin = 1'($urandom);
      if (i % 5 == 0) v.a = 16'h7FFF ^ 16'($urandom_range(0, 3));
      model(16, v.a, v.b, v.sub, v.cin, r, co, ov);
      v.s = r; v.co = co; v.ov = ov;
      v.hold = $urandom_range(0, 2);
      run_op16(v);
    end

    run_op4(4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      model(4, {12'h0, ra}, {12'h0, rb}, rs, rc, r, co, ov);
      run_op4(ra, rb, rs, rc, r[3:0], co, ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
